serial_add_sub: RTL and testbench

Parametrised multi-cycle adder/subtractor. It is the sequential successor to the single-bit full adder. Operands are latched on a start handshake, and the block ripples a slice of BITS_PER_CYCLE bits per clock through one shared carry flop. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It serves area-constrained datapaths where latency is acceptable.

---
 rtl/serial_add_sub.sv | 146 ++++++++++++++
 tb/tb_serial_add_sub.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - multi-cycle slice-serial adder/subtractor with shared carry flop
module serial_add_sub #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
         $error("serial_add_sub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic                      w_accept;
   logic [WIDTH-1:0]          r_a;
   logic [WIDTH-1:0]          r_b;
   logic                      r_c;
   logic [CW-1:0]             r_cnt;
   logic [WIDTH-1:0]          r_s;
   logic                      r_co;
   logic                      r_ovf;
   logic [31:0]               w_shamt;
   logic [BITS_PER_CYCLE-1:0] w_slice_a;
   logic [BITS_PER_CYCLE-1:0] w_slice_b;
   logic [BITS_PER_CYCLE-1:0] w_sum;
   logic                      w_cout;
   logic                      w_cin_top;
   logic [WIDTH-1:0]          w_mask;

   // Ripple the current slice; also keep the carry into the slice's top bit,
   // which on the final slice is the carry into the result MSB.
   always_comb begin
      logic v_c;
      w_shamt   = 32'(r_cnt) * 32'(BITS_PER_CYCLE);
      w_slice_a = BITS_PER_CYCLE'(r_a >> w_shamt);
      w_slice_b = BITS_PER_CYCLE'(r_b >> w_shamt);
      w_mask    = WIDTH'({BITS_PER_CYCLE{1'b1}});
      w_sum     = '0;
      w_cin_top = 1'b0;
      v_c       = r_c;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         w_cin_top = v_c;
         w_sum[i]  = w_slice_a[i] ^ w_slice_b[i] ^ v_c;
         v_c       = (w_slice_a[i] & w_slice_b[i]) | (v_c & (w_slice_a[i] ^ w_slice_b[i]));
      end
      w_cout = v_c;
   end

   // Next-state logic; a start is accepted from IDLE or straight out of DONE.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next   = S_RUN;
               w_accept = 1'b1;
            end
         end
         S_RUN: begin
            if (r_cnt == LAST) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_next   = S_RUN;
               w_accept = 1'b1;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Datapath: latch conditioned operands on accept, then one slice per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= 1'b0;
         r_cnt <= '0;
         r_s   <= '0;
         r_co  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= sub ? ~b : b;
         r_c   <= sub ? ~ci : ci;
         r_cnt <= '0;
         r_s   <= '0;
         r_co  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_s <= (r_s & ~(w_mask << w_shamt)) | (WIDTH'(w_sum) << w_shamt);
         r_c <= w_cout;
         if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_co  <= w_cout;
            r_ovf <= w_cin_top ^ w_cout;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Status flags decode straight from state, so reset clears them immediately.
   always_comb begin
      busy = (r_state == S_RUN);
      done = (r_state == S_DONE);
      s    = r_s;
      co   = r_co;
      ovf  = r_ovf;
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - scoreboard bench for serial_add_sub (8-bit directed, 4-bit sweep)
module tb_serial_add_sub;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       ovf;
      int         es;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start8, sub8, ci8;
   logic [7:0] a8, b8;
   logic       busy8, done8, co8, ovf8;
   logic [7:0] s8;

   logic       start4, sub4, ci4;
   logic [3:0] a4, b4;
   logic       busy4 [3];
   logic       done4 [3];
   logic       co4   [3];
   logic       ovf4  [3];
   logic [3:0] s4    [3];

   exp_t q8 [$];
   exp_t q4 [3][$];

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int busy_cnt8 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
      .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8)
   );

   // 8-bit monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst) begin
         busy_cnt8 = 0;
      end else begin
         if (busy8) busy_cnt8++;
         if (done8) begin
            chk("w8 busy during done", busy8, 0);
            chk("w8 busy cycles", busy_cnt8, 8);
            busy_cnt8 = 0;
            if (q8.size() == 0) begin
               chk("w8 unexpected done", 1, 0);
            end else begin
               e = q8.pop_front();
               chk("w8 s", s8, e.s);
               chk("w8 co", co8, e.co);
               chk("w8 ovf", ovf8, e.ovf);
               chk("w8 latency", cyc - e.es, 8);
            end
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_w4
      localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      exp_t e4;
      serial_add_sub #(.WIDTH(4), .BITS_PER_CYCLE(BPC)) u_dut4 (
         .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .ci(ci4),
         .busy(busy4[g]), .done(done4[g]), .s(s4[g]), .co(co4[g]), .ovf(ovf4[g])
      );
      always @(negedge clk) begin
         if (!rst && done4[g]) begin
            chk($sformatf("w4b%0d busy during done", BPC), busy4[g], 0);
            if (q4[g].size() == 0) begin
               chk($sformatf("w4b%0d unexpected done", BPC), 1, 0);
            end else begin
               e4 = q4[g].pop_front();
               chk($sformatf("w4b%0d s", BPC), s4[g], e4.s);
               chk($sformatf("w4b%0d co", BPC), co4[g], e4.co);
               chk($sformatf("w4b%0d ovf", BPC), ovf4[g], e4.ovf);
               chk($sformatf("w4b%0d latency", BPC), cyc - e4.es, 4 / BPC);
            end
         end
      end
   end

   function automatic exp_t model4(input int a, input int b, input int ci, input int sub, input int es);
      exp_t e;
      int r, sr, sa, sb;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      if (sub != 0) begin
         r  = a + (15 - b) + (1 - ci);
         sr = sa - sb - ci;
      end else begin
         r  = a + b + ci;
         sr = sa + sb + ci;
      end
      e.s   = 8'(r & 15);
      e.co  = ((r >> 4) & 1) != 0;
      e.ovf = (sr > 7) || (sr < -8);
      e.es  = es;
      return e;
   endfunction

   // Called just after a posedge; the next edge samples start.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub,
                         input logic push, input logic [7:0] es_s, input logic eco, input logic eovf);
      exp_t e;
      a8 = a; b8 = b; ci8 = ci; sub8 = sub; start8 = 1'b1;
      if (push) begin
         e.s = es_s; e.co = eco; e.ovf = eovf; e.es = cyc + 1;
         q8.push_back(e);
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      a8 = ~a; b8 = ~b; ci8 = ~ci; sub8 = ~sub;
      chk("w8 s cleared on latch", s8, 0);
      chk("w8 co cleared on latch", co8, 0);
      chk("w8 ovf cleared on latch", ovf8, 0);
   endtask

   task automatic wait_done8();
      int n = 0;
      while (!done8 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done8) chk("w8 done timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start8 = 0; sub8 = 0; ci8 = 0; a8 = 0; b8 = 0;
      start4 = 0; sub4 = 0; ci4 = 0; a4 = 0; b4 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", busy8, 0);
      chk("reset done", done8, 0);
      chk("reset s", s8, 0);
      chk("reset co", co8, 0);
      chk("reset ovf", ovf8, 0);
      chk("reset w4 busy", busy4[0], 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed 8-bit vectors.
      issue8(8'h5A, 8'h3C, 0, 0, 1, 8'h96, 0, 1);
      wait_done8();
      repeat (3) @(posedge clk);
      #1;
      chk("hold s", s8, 8'h96);
      chk("hold co", co8, 0);
      chk("hold ovf", ovf8, 1);
      issue8(8'hFF, 8'h01, 1, 0, 1, 8'h01, 1, 0);
      wait_done8();
      issue8(8'h10, 8'h20, 0, 1, 1, 8'hF0, 0, 0);
      wait_done8();
      issue8(8'h80, 8'h01, 0, 1, 1, 8'h7F, 1, 1);
      wait_done8();

      // Start during RUN is ignored.
      @(posedge clk); #1;
      issue8(8'h33, 8'h11, 0, 0, 1, 8'h44, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8();

      // Back-to-back from the DONE cycle.
      @(posedge clk); #1;
      issue8(8'h01, 8'h01, 0, 0, 1, 8'h02, 0, 0);
      wait_done8();
      issue8(8'h7F, 8'h01, 0, 0, 1, 8'h80, 0, 1);
      wait_done8();

      // Mid-operation reset aborts with no done.
      @(posedge clk); #1;
      issue8(8'hFF, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("pre-abort s", s8, 8'h07);
      #2 rst = 1'b1;
      #1;
      chk("abort busy", busy8, 0);
      chk("abort done", done8, 0);
      chk("abort s", s8, 0);
      chk("abort co", co8, 0);
      chk("abort ovf", ovf8, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue8(8'hC8, 8'h64, 1, 1, 1, 8'h63, 1, 1);
      wait_done8();

      // Exhaustive 4-bit sweep across all three slice widths.
      for (int sb = 0; sb < 2; sb++) begin
         for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < 16; x++) begin
               for (int y = 0; y < 16; y++) begin
                  int n;
                  a4 = 4'(x); b4 = 4'(y); ci4 = c[0]; sub4 = sb[0]; start4 = 1'b1;
                  for (int g = 0; g < 3; g++) q4[g].push_back(model4(x, y, c, sb, cyc + 1));
                  @(posedge clk); #1;
                  start4 = 1'b0;
                  n = 0;
                  while (!done4[0] && n < 10) begin
                     @(posedge clk); #1;
                     n++;
                  end
                  if (!done4[0]) chk("w4 done timeout", 0, 1);
               end
            end
         end
      end

      repeat (6) @(posedge clk);
      #1;
      chk("w8 queue drained", q8.size(), 0);
      chk("w4b1 queue drained", q4[0].size(), 0);
      chk("w4b2 queue drained", q4[1].size(), 0);
      chk("w4b4 queue drained", q4[2].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
